// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Bus-master front end for the 16-bit data memory. Accepts one load/store
// at a time through a valid/ready handshake, drives memrq/rw/addr/mem_wdata
// for 1+WAIT_CYCLES cycles, captures load data and returns a one-cycle
// completion strobe.
//
// Optional feature macro: MEM_RANGE_CHECK_EN
//   When defined, requests with req_addr >= MEM_DEPTH skip the memory access
//   and complete with resp_err=1 one cycle after acceptance.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready core request handshake (ready is combinational)
//   req_we          1 = store, 0 = load
//   req_addr        word address
//   req_wdata       store data
//   resp_valid      one-cycle completion strobe
//   resp_rdata      last load data, held until the next load completes
//   resp_err        out-of-range flag (MEM_RANGE_CHECK_EN only)
//   memrq, rw       memory request, 1 = read / 0 = write
//   addr, mem_wdata memory address and write data
//   mem_rdata       combinational memory read data
module mem_access_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int MEM_DEPTH   = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
`ifdef MEM_RANGE_CHECK_EN
    output logic              resp_err,
`endif
    output logic              memrq,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    // True when a word address lies beyond the implemented memory.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= (ADDR_W+1)'(MEM_DEPTH));
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic                accept_s;
    logic                range_err_s;
    logic                access_we_s;
    logic                we_r;
    logic [3:0]          wait_cnt_r;
    logic                memrq_r;
    logic                rw_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                resp_valid_r;
    logic [DATA_W-1:0]   resp_rdata_r;
    logic                resp_err_r;

`ifdef MEM_RANGE_CHECK_EN
    assign range_err_s = addr_out_of_range(req_addr);
    assign resp_err    = resp_err_r;
`else
    assign range_err_s = 1'b0;
`endif

    assign req_ready  = (state_r == ST_IDLE) && !rst;
    assign memrq      = memrq_r;
    assign rw         = rw_r;
    assign addr       = addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; also flags the accepting cycle and the direction
    // that the next ACCESS cycle will drive.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        access_we_s  = we_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s    = 1'b1;
                    access_we_s = req_we;
                    if (range_err_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_ACCESS;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (wait_cnt_r == 4'd0) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Registered memory-side outputs, request latches and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memrq_r     <= 1'b0;
            rw_r        <= 1'b1;
            addr_r      <= '0;
            mem_wdata_r <= '0;
            we_r        <= 1'b0;
            wait_cnt_r  <= 4'd0;
        end else begin
            memrq_r <= (next_state_s == ST_ACCESS);
            rw_r    <= !((next_state_s == ST_ACCESS) && access_we_s);
            // Out-of-range requests never reach memory, so the bus keeps
            // its previous address/data.
            if (accept_s && !range_err_s) begin
                addr_r      <= req_addr;
                mem_wdata_r <= req_wdata;
                we_r        <= req_we;
            end else begin
                addr_r      <= addr_r;
                mem_wdata_r <= mem_wdata_r;
                we_r        <= we_r;
            end
            if (accept_s) begin
                wait_cnt_r <= WAIT_L;
            end else if ((state_r == ST_ACCESS) && (wait_cnt_r != 4'd0)) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Response strobe, load-data capture and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
        end else begin
            resp_valid_r <= (next_state_s == ST_DONE);
            resp_err_r   <= (next_state_s == ST_DONE) && (state_r == ST_IDLE);
            // Loads sample memory on the last ACCESS edge; stores leave it.
            if ((state_r == ST_ACCESS) && (next_state_s == ST_DONE) && !we_r) begin
                resp_rdata_r <= mem_rdata;
            end else begin
                resp_rdata_r <= resp_rdata_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int NDUT = 3;

    logic              clk;
    logic [2:0]        rst;
    logic [2:0]        req_valid;
    logic [2:0]        req_ready;
    logic [2:0]        req_we;
    logic [11:0]       req_addr  [NDUT];
    logic [15:0]       req_wdata [NDUT];
    logic [2:0]        resp_valid;
    logic [15:0]       resp_rdata [NDUT];
`ifdef MEM_RANGE_CHECK_EN
    logic [2:0]        resp_err;
`endif
    logic [2:0]        memrq;
    logic [2:0]        rw;
    logic [11:0]       addr      [NDUT];
    logic [15:0]       mem_wdata [NDUT];
    logic [15:0]       mem_rdata [NDUT];

    logic [15:0]       mem [NDUT][32];
    logic              preload;

    logic [15:0]       ref_mem [NDUT][32];
    logic [15:0]       ref_rd  [NDUT];

    int checks;
    int failures;

    typedef struct {
        logic        we;
        logic [11:0] a;
        logic [15:0] d;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl [7];

    function automatic int wc(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_access_ctrl #(
            .ADDR_W(12), .DATA_W(16), .MEM_DEPTH(32),
            .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .clk(clk),
            .rst(rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we(req_we[g]),
            .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_rdata(resp_rdata[g]),
`ifdef MEM_RANGE_CHECK_EN
            .resp_err(resp_err[g]),
`endif
            .memrq(memrq[g]),
            .rw(rw[g]),
            .addr(addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory arrays: preload, then commit writes on every edge of a write request.
    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (preload) begin
                for (int i = 0; i < 32; i++) mem[g][i] <= (i == 7) ? 16'h1234 : 16'h0000;
            end else if (memrq[g] && !rw[g] && (addr[g] < 12'd32)) begin
                mem[g][addr[g][4:0]] <= mem_wdata[g];
            end
        end
    end

    // Combinational memory read.
    always_comb begin
        for (int g = 0; g < NDUT; g++) begin
            mem_rdata[g] = (addr[g] < 12'd32) ? mem[g][addr[g][4:0]] : 16'h0000;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One transaction on DUT k with full timing/bus checks.
    task automatic run_req(input int k, input logic we, input logic [11:0] a,
                           input logic [15:0] d, input logic [15:0] exp_rd);
        int cyc;
        int mrq;
        int rv_at;
        logic busy_ready;
        @(negedge clk);
        cyc = 0;
        while (!req_ready[k] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("ready_before_req d%0d", k), 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = a;
        req_wdata[k] = d;
        @(negedge clk);
        // Later changes to the request inputs must be ignored.
        req_valid[k] = 1'b0;
        req_addr[k]  = a ^ 12'h001;
        req_wdata[k] = 16'h0000;
        mrq = 0;
        rv_at = -1;
        busy_ready = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (req_ready[k]) busy_ready = 1'b1;
            if (memrq[k]) begin
                mrq++;
                chk($sformatf("rw d%0d a%0d", k, a), 32'(rw[k]), 32'(!we));
                chk($sformatf("addr d%0d", k), 32'(addr[k]), 32'(a));
                if (we) chk($sformatf("mem_wdata d%0d", k), 32'(mem_wdata[k]), 32'(d));
            end
            if (resp_valid[k]) begin
                rv_at = c;
                chk($sformatf("rdata d%0d a%0d", k, a), 32'(resp_rdata[k]), 32'(exp_rd));
                chk($sformatf("memrq_in_done d%0d", k), 32'(memrq[k]), 32'd0);
                chk($sformatf("rw_in_done d%0d", k), 32'(rw[k]), 32'd1);
`ifdef MEM_RANGE_CHECK_EN
                chk($sformatf("resp_err d%0d", k), 32'(resp_err[k]), 32'd0);
`endif
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("memrq_cycles d%0d", k), 32'(mrq), 32'(wc(k) + 1));
        chk($sformatf("resp_latency d%0d", k), 32'(rv_at), 32'(wc(k) + 2));
        chk($sformatf("ready_low_busy d%0d", k), 32'(busy_ready), 32'd0);
        @(negedge clk);
        chk($sformatf("resp_one_cycle d%0d", k), 32'(resp_valid[k]), 32'd0);
        chk($sformatf("ready_again d%0d", k), 32'(req_ready[k]), 32'd1);
    endtask

    // Transaction whose expectation comes from the reference model.
    task automatic ref_req(input int k, input logic we, input logic [11:0] a, input logic [15:0] d);
        logic [15:0] exp;
        exp = we ? ref_rd[k] : ref_mem[k][a[4:0]];
        run_req(k, we, a, d, exp);
        if (we) ref_mem[k][a[4:0]] = d;
        else    ref_rd[k] = exp;
    endtask

    initial begin
        logic saw_rv;
        logic saw_mrq;
        checks = 0;
        failures = 0;
        preload = 1'b1;
        rst = 3'b111;
        req_valid = 3'b000;
        req_we = 3'b000;
        for (int k = 0; k < NDUT; k++) begin
            req_addr[k] = 12'h000;
            req_wdata[k] = 16'h0000;
            ref_rd[k] = 16'h0000;
            for (int i = 0; i < 32; i++) ref_mem[k][i] = (i == 7) ? 16'h1234 : 16'h0000;
        end

        tbl[0] = '{1'b1, 12'd5, 16'hBEEF, 16'h0000};
        tbl[1] = '{1'b0, 12'd5, 16'h0000, 16'hBEEF};
        tbl[2] = '{1'b1, 12'd6, 16'h1357, 16'hBEEF};
        tbl[3] = '{1'b0, 12'd7, 16'h0000, 16'h1234};
        tbl[4] = '{1'b0, 12'd6, 16'h0000, 16'h1357};
        tbl[5] = '{1'b1, 12'd5, 16'h0000, 16'h1357};
        tbl[6] = '{1'b0, 12'd5, 16'hFFFF, 16'h0000};

        repeat (2) @(negedge clk);
        preload = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("rst_memrq d%0d", k), 32'(memrq[k]), 32'd0);
            chk($sformatf("rst_rw d%0d", k), 32'(rw[k]), 32'd1);
            chk($sformatf("rst_addr d%0d", k), 32'(addr[k]), 32'd0);
            chk($sformatf("rst_wdata d%0d", k), 32'(mem_wdata[k]), 32'd0);
            chk($sformatf("rst_resp_valid d%0d", k), 32'(resp_valid[k]), 32'd0);
            chk($sformatf("rst_rdata d%0d", k), 32'(resp_rdata[k]), 32'd0);
            chk($sformatf("rst_ready d%0d", k), 32'(req_ready[k]), 32'd0);
`ifdef MEM_RANGE_CHECK_EN
            chk($sformatf("rst_err d%0d", k), 32'(resp_err[k]), 32'd0);
`endif
        end
        rst = 3'b000;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("ready_after_rst d%0d", k), 32'(req_ready[k]), 32'd1);

        // Directed table on the zero-wait instance.
        for (int i = 0; i < 7; i++) begin
            run_req(0, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].exp_rd);
            if (tbl[i].we) ref_mem[0][tbl[i].a[4:0]] = tbl[i].d;
            else           ref_rd[0] = tbl[i].exp_rd;
        end

        // Three wait states: preloaded word.
        run_req(1, 1'b0, 12'd7, 16'h0000, 16'h1234);
        ref_rd[1] = 16'h1234;

        // Store whose request data changes during ACCESS.
        ref_req(0, 1'b1, 12'd9, 16'hBEEF);
        chk("mem9_after_store", 32'(mem[0][9]), 32'h0000BEEF);
        ref_req(0, 1'b0, 12'd9, 16'h0000);

        // Reset during the second ACCESS cycle (two wait states).
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2] = 1'b1;
        req_addr[2] = 12'd10;
        req_wdata[2] = 16'h5555;
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk("midrst_memrq_first", 32'(memrq[2]), 32'd1);
        @(negedge clk);
        chk("midrst_memrq_second", 32'(memrq[2]), 32'd1);
        rst[2] = 1'b1;
        #1;
        chk("midrst_memrq_drop", 32'(memrq[2]), 32'd0);
        chk("midrst_ready", 32'(req_ready[2]), 32'd0);
        chk("midrst_resp", 32'(resp_valid[2]), 32'd0);
        @(negedge clk);
        rst[2] = 1'b0;
        ref_rd[2] = 16'h0000;
        saw_rv = 1'b0;
        saw_mrq = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid[2]) saw_rv = 1'b1;
            if (memrq[2]) saw_mrq = 1'b1;
        end
        chk("midrst_no_resp", 32'(saw_rv), 32'd0);
        chk("midrst_no_memrq", 32'(saw_mrq), 32'd0);
        chk("midrst_ready_after", 32'(req_ready[2]), 32'd1);
        ref_req(2, 1'b0, 12'd7, 16'h0000);
        ref_req(2, 1'b1, 12'd10, 16'hA5A5);

`ifdef MEM_RANGE_CHECK_EN
        // Out-of-range load completes without touching memory.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0] = 1'b0;
        req_addr[0] = 12'd40;
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("range_resp_valid", 32'(resp_valid[0]), 32'd1);
        chk("range_resp_err", 32'(resp_err[0]), 32'd1);
        chk("range_memrq", 32'(memrq[0]), 32'd0);
        chk("range_rdata", 32'(resp_rdata[0]), 32'(ref_rd[0]));
        @(negedge clk);
        chk("range_memrq_after", 32'(memrq[0]), 32'd0);
        chk("range_resp_clear", 32'(resp_valid[0]), 32'd0);
        chk("range_ready", 32'(req_ready[0]), 32'd1);
`endif

        // Randomized traffic against the reference model.
        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 40; n++) begin
                ref_req(k, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)),
                        16'($urandom));
            end
        end

        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < 32; i++)
                chk($sformatf("mem d%0d w%0d", k, i), 32'(mem[k][i]), 32'(ref_mem[k][i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Bus-master front end for the 16-bit data memory. It accepts single load/store requests from the CPU core through a valid/ready handshake and drives the memory's `memrq`/`rw`/`addr`/data lines for a configurable number of cycles. It captures read data into a register and returns a one-cycle response strobe. It sits between the core's execute/memory stage and the memory array, and is the only driver of the memory request lines.

## Interface
- `ADDR_W`, 12: address width, matching the memory `addr` port.
- `DATA_W`, 16: data word width.
- `MEM_DEPTH`, 32: number of implemented words; used only by the range check.
- `WAIT_CYCLES`, 0: extra cycles `memrq` is held beyond the first access cycle (0–15).

Ports, clock and reset first:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  controller can accept; high only in IDLE with `rst` low.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  store data.
- `resp_valid`  out  1  one-cycle completion strobe for load and store.
- `resp_rdata`  out  DATA_W  load data; valid when `resp_valid` is high, held until the next load completes.
- `resp_err`  out  1  out-of-range flag, qualified by `resp_valid`. Present only with `MEM_RANGE_CHECK_EN`.
- `memrq`  out  1  memory request.
- `rw`  out  1  1 = read, 0 = write. This is the memory's encoding.
- `addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  drives memory `in_data`.
- `mem_rdata`  in  DATA_W  from memory `out_data`; combinational read.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid` it latches `req_we`, `req_addr` and `req_wdata`, and goes to ACCESS.
  - ACCESS: `memrq`=1, `rw`=~latched_we, with `addr` and `mem_wdata` from the latches. A wait counter loads `WAIT_CYCLES` on entry and decrements each cycle. When the counter is 0, the FSM goes to DONE. On that same edge, a load captures `mem_rdata` into `resp_rdata`.
  - DONE: `resp_valid`=1 and `memrq`=0. The FSM goes to IDLE unconditionally.
- Requests are not accepted in ACCESS or DONE, so at most one request is outstanding.
- Request inputs are sampled only on the accepting edge. Later changes are ignored.
- Stores: memory commits on every edge while `memrq` and `~rw` hold. The same word and data are repeated, so multi-cycle writes are idempotent.
- Stores leave `resp_rdata` unchanged.
- `addr` and `mem_wdata` hold their last values outside ACCESS. `rw` returns to 1 outside ACCESS.
- Reset values:
  - `memrq`=0, `rw`=1, `addr`=0, `mem_wdata`=0.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `req_ready`=0 while `rst` is high. The state is IDLE.
- Reset mid-operation: `memrq` drops immediately and asynchronously. An in-flight store may or may not have committed. No response is issued. After release, the FSM is in IDLE with `req_ready`=1.

## Timing
- Accepting edge at cycle N. `memrq` is high for cycles N+1 … N+1+`WAIT_CYCLES`.
- `resp_valid` is high in cycle N+2+`WAIT_CYCLES` for exactly one cycle.
- `req_ready` goes high again in cycle N+3+`WAIT_CYCLES`.
- Throughput is one request per 3+`WAIT_CYCLES` cycles.
- `req_ready` is a combinational decode of the state and `rst`. All other outputs are registered.

## Configuration
- `MEM_RANGE_CHECK_EN` defined:
  - An accepted request with `req_addr` ≥ `MEM_DEPTH` skips ACCESS and goes directly to DONE.
  - `memrq` is never asserted for that request.
  - `resp_err`=1 with `resp_valid`. `resp_rdata` is unchanged.
  - Latency is 1 cycle from acceptance to `resp_valid`.
- `MEM_RANGE_CHECK_EN` undefined:
  - No check is made. All addresses are issued to memory.
  - The `resp_err` port does not exist.

## Test plan
- Reset with `WAIT_CYCLES`=0 → all outputs at their reset values; `req_ready`=1 one cycle after `rst` falls.
- Store 0xBEEF to address 5, then load address 5 → `memrq` high for 1 cycle each, `rw`=0 then 1; `resp_rdata`=0xBEEF in the load's DONE cycle.
- `WAIT_CYCLES`=3, load address 7 preloaded with 0x1234 → `memrq` high for exactly 4 cycles; `resp_valid` 5 cycles after acceptance; `resp_rdata`=0x1234.
- Change `req_wdata` from 0xBEEF to 0x0000 during ACCESS of a store to address 9 → memory[9]=0xBEEF; `req_ready`=0 throughout ACCESS and DONE.
- Assert `rst` during the second ACCESS cycle with `WAIT_CYCLES`=2 → `memrq`=0 in the same cycle; no `resp_valid`; next load completes normally.
- With `MEM_RANGE_CHECK_EN`, load address 40 → `memrq` never asserted; `resp_valid`=1 and `resp_err`=1 one cycle after acceptance; `resp_rdata` unchanged.
